ah4_atu_responder: RTL and testbench



---
 rtl/ah4_atu_responder_pkg.sv | 24 ++
 rtl/ah4_atu_responder_if.sv | 26 ++
 rtl/ah4_atu_responder_ms_tick.sv | 52 +++++
 rtl/ah4_atu_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_ah4_atu_responder.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ah4_atu_responder_pkg.sv
// ah4_pkg: shared types and helpers for the AH-4 ATU responder.
// States, tune result codes and ms-to-clock conversion.
package ah4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    STUCK,
    RESP,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_MATCH   = 2'b01;
  localparam logic [1:0] RES_EXHAUST = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/ah4_atu_responder_if.sv
// ah4_atu_responder_if: two-wire ATU link plus relay drive and status.
// master = rig/bench side, slave = tuner responder.
interface ah4_atu_responder_if #(
  parameter int CODE_W = 8
);
  logic              start_in;
  logic              rf_present;
  logic              swr_ok;
  logic              key_out;
  logic [CODE_W-1:0] relay_code;
  logic              relay_stb;
  logic              tune_done;
  logic [1:0]        tune_result;

  modport master (
    output start_in, rf_present, swr_ok,
    input  key_out, relay_code, relay_stb,
    input  tune_done, tune_result
  );

  modport slave (
    input  start_in, rf_present, swr_ok,
    output key_out, relay_code, relay_stb,
    output tune_done, tune_result
  );
endinterface

// File: rtl/ah4_atu_responder_ms_tick.sv
// ah4_ms_tick: 1 ms tick prescaler and 2-FF input synchronisers.
// Shared by the responder and the rig-side controller.
module ah4_ms_tick
  import ah4_pkg::*;
#(
  parameter int CLK_HZ = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_in,
  input  logic rf_present,
  input  logic swr_ok,
  output logic tick,
  output logic start_s,
  output logic rf_s,
  output logic swr_s
);
  localparam int DIV = ms_to_ticks(CLK_HZ, 1);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    s1;
  logic [2:0]    s2;

  // down-counter prescaler, tick while at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

  // two-stage synchroniser for the asynchronous inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {start_in, rf_present, swr_ok};
      s2 <= s1;
    end
  end

  assign {start_s, rf_s, swr_s} = s2;

endmodule

// File: rtl/ah4_atu_responder.sv
// ah4_atu_responder: qualifies START, keys busy, steps relay codes to match.
// Define AH4_ATU_RESPONDER_MEMORY_EN to retry the last matched code first.
module ah4_atu_responder
  import ah4_pkg::*;
#(
  parameter int CLK_HZ        = 2500000,
  parameter int MIN_START_MS  = 200,
  parameter int MAX_START_MS  = 1000,
  parameter int RESP_DELAY_MS = 50,
  parameter int STEP_MS       = 10,
  parameter int TUNE_LIMIT_MS = 8000,
  parameter int CODE_W        = 8
) (
  input logic                clk,
  input logic                rst_n,
  ah4_atu_responder_if.slave bus
);
  localparam logic [15:0] T_MIN  = 16'(MIN_START_MS);
  localparam logic [15:0] T_MAX  = 16'(MAX_START_MS);
  localparam logic [15:0] T_RESP = 16'(RESP_DELAY_MS);
  localparam logic [15:0] T_STEP = 16'(STEP_MS);
  localparam logic [15:0] T_LIM  = 16'(TUNE_LIMIT_MS);
  localparam logic [CODE_W-1:0] C_MAX = '1;
  localparam logic [CODE_W-1:0] C_ONE = CODE_W'(1);

  state_t            st_q, st_d;
  logic [15:0]       wid_q, wid_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [15:0]       lim_q, lim_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] first_code;
  logic [1:0]        res_q, res_d;
  logic              key_q, key_d;
  logic              done_q, done_d;
  logic              stb_q;
  logic              tick, start_s, rf_s, swr_s;
  logic              expire;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
  logic [CODE_W-1:0] mem_q, mem_d;
  logic              try_q, try_d;
`endif

  ah4_ms_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (bus.start_in),
    .rf_present(bus.rf_present),
    .swr_ok    (bus.swr_ok),
    .tick      (tick),
    .start_s   (start_s),
    .rf_s      (rf_s),
    .swr_s     (swr_s)
  );

  assign expire = key_q &&
    ((lim_q == '0) || (tick && lim_q == 16'd1));

`ifdef AH4_ATU_RESPONDER_MEMORY_EN
  assign first_code = (mem_q != '0) ? mem_q : C_ONE;
`else
  assign first_code = C_ONE;
`endif

  // next-state and datapath decisions
  always_comb begin
    st_d   = st_q;
    wid_d  = wid_q;
    tmr_d  = tmr_q;
    lim_d  = lim_q;
    code_d = code_q;
    res_d  = res_q;
    key_d  = key_q;
    done_d = 1'b0;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
    mem_d  = mem_q;
    try_d  = try_q;
`endif
    if (key_q && tick && lim_q != '0) begin
      lim_d = lim_q - 16'd1;
    end
    unique case (st_q)
      IDLE: begin
        if (start_s) begin
          wid_d = '0;
          st_d  = MEAS;
        end
      end
      MEAS: begin
        if (!start_s) begin
          if (wid_q >= T_MIN && wid_q <= T_MAX) begin
            res_d = RES_NONE;
            tmr_d = T_RESP;
            st_d  = RESP;
          end else begin
            st_d = IDLE;
          end
        end else if (tick) begin
          if (wid_q >= T_MAX) begin
            st_d = STUCK;
          end else begin
            wid_d = wid_q + 16'd1;
          end
        end
      end
      STUCK: begin
        if (!start_s) begin
          st_d = IDLE;
        end
      end
      RESP: begin
        if (tick) begin
          if (tmr_q <= 16'd1) begin
            key_d  = 1'b1;
            lim_d  = T_LIM;
            code_d = first_code;
            tmr_d  = T_STEP;
            st_d   = SETTLE;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
            try_d  = (mem_q != '0);
`endif
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
      end
      SETTLE: begin
        if (expire) begin
          res_d  = RES_TIMEOUT;
          code_d = '0;
          key_d  = 1'b0;
          done_d = 1'b1;
          st_d   = DONE;
        end else if (tick) begin
          if (tmr_q <= 16'd1) begin
            st_d = SAMPLE;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
      end
      SAMPLE: begin
        tmr_d = T_STEP;
        st_d  = SETTLE;
        if (expire) begin
          res_d  = RES_TIMEOUT;
          code_d = '0;
          key_d  = 1'b0;
          done_d = 1'b1;
          st_d   = DONE;
        end else if (rf_s && swr_s) begin
          res_d  = RES_MATCH;
          key_d  = 1'b0;
          done_d = 1'b1;
          st_d   = DONE;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
          mem_d  = code_q;
`endif
        end else if (!rf_s) begin
          code_d = code_q;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
        end else if (try_q) begin
          code_d = C_ONE;
          try_d  = 1'b0;
`endif
        end else if (code_q == C_MAX) begin
          res_d  = RES_EXHAUST;
          code_d = '0;
          key_d  = 1'b0;
          done_d = 1'b1;
          st_d   = DONE;
        end else begin
          code_d = code_q + C_ONE;
        end
      end
      DONE: begin
        st_d = IDLE;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
        try_d = 1'b0;
`endif
      end
      default: st_d = IDLE;
    endcase
  end

  // state and output registers; strobe only on a real code change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      wid_q  <= '0;
      tmr_q  <= '0;
      lim_q  <= '0;
      code_q <= '0;
      res_q  <= RES_NONE;
      key_q  <= 1'b0;
      done_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wid_q  <= wid_d;
      tmr_q  <= tmr_d;
      lim_q  <= lim_d;
      code_q <= code_d;
      res_q  <= res_d;
      key_q  <= key_d;
      done_q <= done_d;
      stb_q  <= (code_d != code_q);
    end
  end

`ifdef AH4_ATU_RESPONDER_MEMORY_EN
  // last matched code and first-try flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      try_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      try_q <= try_d;
    end
  end
`endif

  assign bus.key_out     = key_q;
  assign bus.relay_code  = code_q;
  assign bus.relay_stb   = stb_q;
  assign bus.tune_done   = done_q;
  assign bus.tune_result = res_q;

endmodule

// File: tb/tb_ah4_atu_responder.sv
// tb_ah4_atu_responder: directed bench, CLK_HZ=2000 (1 ms = 2 clk), CODE_W=4.
// Follows AH4_ATU_RESPONDER_MEMORY_EN for the memory scenario.
module tb_ah4_atu_responder;
  import ah4_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic          swr_en = 1'b0;
  logic [CW-1:0] swr_code = '0;

  int            stb_cnt = 0;
  int            done_cnt = 0;
  int            rise_cnt = 0;
  int            key_rise = 0;
  int            key_fall = 0;
  int            bad_stb = 0;
  int            t_rel = 0;
  logic [CW-1:0] rise_code = '0;
  logic [CW-1:0] code_prev = '0;
  logic          key_prev = 1'b0;
  logic          rst_q = 1'b0;
  int            stb_t[$];
  logic [CW-1:0] stb_c[$];

  always #5 clk = ~clk;

  ah4_atu_responder_if #(.CODE_W(CW)) bus();

  ah4_atu_responder #(
    .CLK_HZ(2000),
    .CODE_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  always @* bus.swr_ok = swr_en && (bus.relay_code == swr_code);

  always @(negedge clk) begin
    if (bus.relay_stb) begin
      stb_cnt++;
      stb_t.push_back(cyc);
      stb_c.push_back(bus.relay_code);
      if (rst_q && bus.relay_code == code_prev) bad_stb++;
    end else if (rst_q && bus.relay_code != code_prev) begin
      bad_stb++;
    end
    if (bus.tune_done) done_cnt++;
    if (bus.key_out && !key_prev) begin
      rise_cnt++;
      key_rise  = cyc;
      rise_code = bus.relay_code;
    end
    if (!bus.key_out && key_prev) key_fall = cyc;
    key_prev  = bus.key_out;
    code_prev = bus.relay_code;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input int clks);
    @(negedge clk);
    bus.start_in = 1'b1;
    repeat (clks) @(negedge clk);
    bus.start_in = 1'b0;
    t_rel = cyc;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.tune_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start_in   = 1'b0;
    bus.rf_present = 1'b0;
    do_reset();
    checks++;
    if (bus.key_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_key got=%b want=0", bus.key_out);
    end
    checks++;
    if (bus.relay_code !== 4'd0) begin
      failures++;
      $display("FAIL reset_code got=%0d want=0", bus.relay_code);
    end
    checks++;
    if (bus.tune_result !== RES_NONE) begin
      failures++;
      $display("FAIL reset_result got=%0d want=0", bus.tune_result);
    end
    checks++;
    if (bus.relay_stb !== 1'b0 || bus.tune_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b%b want=00",
               bus.relay_stb, bus.tune_done);
    end
  endtask

  task automatic test_match();
    int s0, d0, i0, d;
    bit ok;
    do_reset();
    bus.rf_present = 1'b1;
    swr_en   = 1'b1;
    swr_code = 4'd5;
    s0 = stb_cnt;
    d0 = done_cnt;
    i0 = stb_t.size();
    pulse(1000);
    wait_done(600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL match_done got=0 want=1");
    end
    d = key_rise - t_rel;
    checks++;
    if (d < 98 || d > 108) begin
      failures++;
      $display("FAIL match_key_delay got=%0d want=98..108 clk", d);
    end
    checks++;
    if (rise_code !== 4'd1) begin
      failures++;
      $display("FAIL match_first_code got=%0d want=1", rise_code);
    end
    checks++;
    if (bus.tune_result !== RES_MATCH) begin
      failures++;
      $display("FAIL match_result got=%0d want=1", bus.tune_result);
    end
    checks++;
    if (bus.relay_code !== 4'd5) begin
      failures++;
      $display("FAIL match_code got=%0d want=5", bus.relay_code);
    end
    checks++;
    if (bus.key_out !== 1'b0) begin
      failures++;
      $display("FAIL match_key got=%b want=0", bus.key_out);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL match_done_pulses got=%0d want=1", done_cnt - d0);
    end
    checks++;
    if (stb_cnt - s0 != 5) begin
      failures++;
      $display("FAIL match_stb got=%0d want=5", stb_cnt - s0);
    end
    for (int k = 0; k < 5; k++) begin
      if (i0 + k < stb_c.size()) begin
        checks++;
        if (stb_c[i0+k] !== 4'(k + 1)) begin
          failures++;
          $display("FAIL match_seq%0d got=%0d want=%0d",
                   k, stb_c[i0+k], k + 1);
        end
      end
    end
    for (int k = 1; k < 5; k++) begin
      if (i0 + k < stb_t.size()) begin
        d = stb_t[i0+k] - stb_t[i0+k-1];
        checks++;
        if (d < 19 || d > 23) begin
          failures++;
          $display("FAIL match_hold%0d got=%0d want=19..23 clk", k, d);
        end
      end
    end
    checks++;
    if (bad_stb != 0) begin
      failures++;
      $display("FAIL stb_vs_code got=%0d want=0", bad_stb);
    end
  endtask

  task automatic test_short();
    int r0, s0;
    do_reset();
    r0 = rise_cnt;
    s0 = stb_cnt;
    pulse(200);
    repeat (300) @(negedge clk);
    checks++;
    if (rise_cnt - r0 != 0) begin
      failures++;
      $display("FAIL short_key got=%0d want=0", rise_cnt - r0);
    end
    checks++;
    if (bus.relay_code !== 4'd0 || stb_cnt != s0) begin
      failures++;
      $display("FAIL short_code got=%0d want=0", bus.relay_code);
    end
  endtask

  task automatic test_stuck();
    int r0;
    bit ok;
    do_reset();
    bus.rf_present = 1'b1;
    swr_en   = 1'b1;
    swr_code = 4'd1;
    r0 = rise_cnt;
    pulse(3000);
    repeat (300) @(negedge clk);
    checks++;
    if (rise_cnt - r0 != 0) begin
      failures++;
      $display("FAIL stuck_key got=%0d want=0", rise_cnt - r0);
    end
    pulse(1000);
    wait_done(600, ok);
    checks++;
    if (!ok || rise_cnt - r0 != 1) begin
      failures++;
      $display("FAIL stuck_recover got=%0d want=1", rise_cnt - r0);
    end
    checks++;
    if (bus.tune_result !== RES_MATCH) begin
      failures++;
      $display("FAIL stuck_result got=%0d want=1", bus.tune_result);
    end
  endtask

  task automatic test_exhaust();
    int s0, d;
    bit ok;
    do_reset();
    bus.rf_present = 1'b1;
    swr_en = 1'b0;
    s0 = stb_cnt;
    pulse(1000);
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL exh_done got=0 want=1");
    end
    checks++;
    if (bus.tune_result !== RES_EXHAUST) begin
      failures++;
      $display("FAIL exh_result got=%0d want=2", bus.tune_result);
    end
    checks++;
    if (bus.relay_code !== 4'd0 || bus.key_out !== 1'b0) begin
      failures++;
      $display("FAIL exh_code got=%0d key=%b want=0 0",
               bus.relay_code, bus.key_out);
    end
    checks++;
    if (stb_cnt - s0 != 16) begin
      failures++;
      $display("FAIL exh_stb got=%0d want=16", stb_cnt - s0);
    end
    checks++;
    if (stb_c.size() == 0 || stb_c[$] !== 4'd0) begin
      failures++;
      $display("FAIL exh_last_stb got=%0d want=0",
               stb_c.size() == 0 ? -1 : int'(stb_c[$]));
    end
    d = key_fall - key_rise;
    checks++;
    if (d < 295 || d > 310) begin
      failures++;
      $display("FAIL exh_duration got=%0d want=295..310 clk", d);
    end
  endtask

  task automatic test_timeout();
    int s0, d;
    bit ok;
    do_reset();
    bus.rf_present = 1'b0;
    swr_en = 1'b1;
    swr_code = 4'd1;
    s0 = stb_cnt;
    pulse(1000);
    wait_done(17000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL to_done got=0 want=1");
    end
    checks++;
    if (bus.tune_result !== RES_TIMEOUT) begin
      failures++;
      $display("FAIL to_result got=%0d want=3", bus.tune_result);
    end
    checks++;
    if (bus.relay_code !== 4'd0) begin
      failures++;
      $display("FAIL to_code got=%0d want=0", bus.relay_code);
    end
    checks++;
    if (stb_cnt - s0 != 2) begin
      failures++;
      $display("FAIL to_stb got=%0d want=2", stb_cnt - s0);
    end
    d = key_fall - key_rise;
    checks++;
    if (d < 15998 || d > 16002) begin
      failures++;
      $display("FAIL to_duration got=%0d want=16000 clk", d);
    end
  endtask

  task automatic test_reset_mid();
    int r0, s0;
    bit up;
    do_reset();
    bus.rf_present = 1'b0;
    swr_en = 1'b0;
    pulse(1000);
    up = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.key_out) begin
        up = 1'b1;
        break;
      end
    end
    checks++;
    if (!up) begin
      failures++;
      $display("FAIL mid_key_up got=0 want=1");
    end
    repeat (20) @(negedge clk);
    r0 = rise_cnt;
    s0 = stb_cnt;
    pulse(1000);
    repeat (200) @(negedge clk);
    checks++;
    if (bus.key_out !== 1'b1 || rise_cnt != r0) begin
      failures++;
      $display("FAIL mid_ignore_key got=%b want=1", bus.key_out);
    end
    checks++;
    if (bus.relay_code !== 4'd1 || stb_cnt != s0) begin
      failures++;
      $display("FAIL mid_ignore_code got=%0d want=1", bus.relay_code);
    end
    checks++;
    if (bus.tune_result !== RES_NONE) begin
      failures++;
      $display("FAIL mid_result got=%0d want=0", bus.tune_result);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.key_out !== 1'b0 || bus.relay_code !== 4'd0) begin
      failures++;
      $display("FAIL mid_rst got=%b/%0d want=0/0",
               bus.key_out, bus.relay_code);
    end
    checks++;
    if (bus.tune_result !== RES_NONE) begin
      failures++;
      $display("FAIL mid_rst_result got=%0d want=0", bus.tune_result);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_memory();
    int s0;
    bit ok;
    logic [CW-1:0] exp_first;
    int exp_stb;
`ifdef AH4_ATU_RESPONDER_MEMORY_EN
    exp_first = 4'd5;
    exp_stb   = 0;
`else
    exp_first = 4'd1;
    exp_stb   = 5;
`endif
    do_reset();
    bus.rf_present = 1'b1;
    swr_en   = 1'b1;
    swr_code = 4'd5;
    pulse(1000);
    wait_done(600, ok);
    checks++;
    if (!ok || bus.relay_code !== 4'd5) begin
      failures++;
      $display("FAIL mem_first_tune got=%0d want=5", bus.relay_code);
    end
    s0 = stb_cnt;
    pulse(1000);
    wait_done(600, ok);
    checks++;
    if (!ok || rise_code !== exp_first) begin
      failures++;
      $display("FAIL mem_start_code got=%0d want=%0d",
               rise_code, exp_first);
    end
    checks++;
    if (bus.tune_result !== RES_MATCH) begin
      failures++;
      $display("FAIL mem_result got=%0d want=1", bus.tune_result);
    end
    checks++;
    if (stb_cnt - s0 != exp_stb) begin
      failures++;
      $display("FAIL mem_stb got=%0d want=%0d", stb_cnt - s0, exp_stb);
    end
  endtask

  initial begin
    bus.start_in   = 1'b0;
    bus.rf_present = 1'b0;
    test_reset();
    test_match();
    test_short();
    test_stuck();
    test_exhaust();
    test_timeout();
    test_reset_mid();
    test_memory();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
